// File: rtl/deserializer_nbit.sv
// Serial-to-parallel converter: WIDTH-bit words, first bit in lands in the MSB, runtime bitslip.
// Sync-pattern word alignment (HUNT/VERIFY before data release) compiled in with DESER_ALIGN_EN.
module deserializer_nbit #(
    parameter int               WIDTH        = 5,
    parameter logic [WIDTH-1:0] SYNC_PATTERN = 5'b11100,
    parameter int               LOCK_CNT     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             enable_i,
    input  logic             bitslip_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             align_err_o
);
    localparam int                BCNT_W    = $clog2(WIDTH);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2 || LOCK_CNT < 1 || $bits(SYNC_PATTERN) != WIDTH) begin : g_bad_params
            $error("deserializer_nbit: illegal WIDTH/LOCK_CNT/SYNC_PATTERN");
        end
    endgenerate

`ifdef DESER_ALIGN_EN
    typedef enum logic [1:0] {INIT, HUNT, VERIFY, READ_DATA} state_t;

    localparam int              MC_W    = $clog2(LOCK_CNT + 1);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);

    logic [MC_W-1:0] mcnt;
`else
    typedef enum logic {INIT, READ_DATA} state_t;
`endif

    state_t            state;
    logic [WIDTH-1:0]  sr;
    logic [BCNT_W-1:0] bcnt;
    logic [WIDTH-1:0]  w;

    assign w = {sr[WIDTH-2:0], serial_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            sr       <= '0;
            bcnt     <= '0;
            data_o   <= '0;
            valid_o  <= 1'b0;
            locked_o <= 1'b0;
`ifdef DESER_ALIGN_EN
            mcnt        <= '0;
            align_err_o <= 1'b0;
`endif
        end else begin
            valid_o <= 1'b0;
`ifdef DESER_ALIGN_EN
            align_err_o <= 1'b0;
`endif
            case (state)
                // One dead cycle after reset release; the input is not sampled.
                INIT: begin
`ifdef DESER_ALIGN_EN
                    state <= HUNT;
`else
                    state    <= READ_DATA;
                    locked_o <= 1'b1;
`endif
                end

`ifdef DESER_ALIGN_EN
                HUNT: begin
                    if (enable_i) begin
                        sr <= w;
                        if (w == SYNC_PATTERN) begin
                            bcnt <= '0;
                            mcnt <= MC_W'(1);
                            if (LOCK_CNT == 1) begin
                                state    <= READ_DATA;
                                locked_o <= 1'b1;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                end

                VERIFY: begin
                    if (enable_i) begin
                        sr <= w;
                        if (bcnt == BCNT_LAST) begin
                            bcnt <= '0;
                            if (w == SYNC_PATTERN) begin
                                mcnt <= mcnt + 1'b1;
                                if (mcnt == MC_LAST) begin
                                    state    <= READ_DATA;
                                    locked_o <= 1'b1;
                                end
                            end else begin
                                align_err_o <= 1'b1;
                                mcnt        <= '0;
                                state       <= HUNT;
                            end
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
`endif

                READ_DATA: begin
                    // A bitslip bit is shifted in but not counted, moving the boundary by one.
                    if (enable_i) begin
                        sr <= w;
                        if (!bitslip_i) begin
                            if (bcnt == BCNT_LAST) begin
                                data_o  <= w;
                                valid_o <= 1'b1;
                                bcnt    <= '0;
                            end else begin
                                bcnt <= bcnt + 1'b1;
                            end
                        end
                    end
                end

                default: state <= INIT;
            endcase
        end
    end

`ifndef DESER_ALIGN_EN
    assign align_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer_nbit.sv
// Randomized and directed bench for deserializer_nbit against a bit-history reference model.
module tb_deserializer_nbit;
    localparam int         W     = 5;
    localparam logic [4:0] SYNC  = 5'b11100;
    localparam int         LOCKN = 4;
`ifdef DESER_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_i = 1'b0;
    logic       enable_i = 1'b0;
    logic       bitslip_i = 1'b0;
    logic [4:0] data_o;
    logic       valid_o, locked_o, align_err_o;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    deserializer_nbit dut (
        .clk         (clk),
        .reset       (reset),
        .serial_i    (serial_i),
        .enable_i    (enable_i),
        .bitslip_i   (bitslip_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .locked_o    (locked_o),
        .align_err_o (align_err_o)
    );

    // Reference model: the word is simply the last W bits received; a word completes after
    // W counted bits since the last boundary, bitslip bits being received but not counted.
    bit         hist[$];
    logic [4:0] m_data;
    logic       m_valid, m_locked, m_err;
    bit         m_init, m_hunting;
    int         m_cnt, m_matches;

    function automatic logic [4:0] last_word();
        logic [4:0] v;
        v = '0;
        for (int i = 0; i < hist.size(); i++) v = {v[3:0], hist[i]};
        return v;
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_data = '0; m_valid = 0; m_locked = 0; m_err = 0;
        m_init = 1; m_hunting = 0; m_cnt = 0; m_matches = 0;
    endfunction

    function automatic void model_step(input bit b, input bit en, input bit slip);
        m_valid = 0;
        m_err   = 0;
        if (m_init) begin
            m_init    = 0;
            m_locked  = !ALIGN;
            m_hunting = ALIGN;
            return;
        end
        if (!en) return;
        hist.push_back(b);
        if (hist.size() > W) void'(hist.pop_front());
        if (m_locked) begin
            if (!slip) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == W) begin
                    m_cnt = 0; m_valid = 1; m_data = last_word();
                end
            end
        end else if (m_hunting) begin
            if (last_word() == SYNC) begin
                m_cnt = 0; m_matches = 1; m_hunting = 0;
                if (m_matches == LOCKN) m_locked = 1;
            end
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == W) begin
                m_cnt = 0;
                if (last_word() == SYNC) begin
                    m_matches = m_matches + 1;
                    if (m_matches == LOCKN) m_locked = 1;
                end else begin
                    m_err = 1; m_matches = 0; m_hunting = 1;
                end
            end
        end
    endfunction

    task automatic drive(input bit b, input bit en, input bit slip);
        serial_i  = b;
        enable_i  = en;
        bitslip_i = slip;
        @(posedge clk);
        model_step(b, en, slip);
        #1;
    endtask

    task automatic assert_reset();
        #2;
        reset = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        enable_i = 1'b0;
        bitslip_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({data_o, valid_o, locked_o, align_err_o} !== 8'h00) begin
            fails++;
            $display("FAIL reset_state: got d=%b v=%b l=%b e=%b, expected all 0",
                     data_o, valid_o, locked_o, align_err_o);
        end
        release_reset();
    endtask

    task automatic test_basic();
        bit bits[5] = '{1, 0, 1, 1, 0};
        drive(0, 1, 0);
        checks++;
        if (locked_o !== 1'b1) begin
            fails++;
            $display("FAIL basic_locked_edge1: got %b, expected 1", locked_o);
        end
        for (int i = 0; i < 5; i++) begin
            drive(bits[i], 1, 0);
            checks++;
            if (valid_o !== (i == 4)) begin
                fails++;
                $display("FAIL basic_valid bit%0d: got %b, expected %b", i, valid_o, (i == 4));
            end
        end
        checks++;
        if (data_o !== 5'b10110) begin
            fails++;
            $display("FAIL basic_data: got %b, expected 10110", data_o);
        end
    endtask

    task automatic test_gap();
        bit bits[8] = '{0, 1, 0, 0, 0, 1, 0, 0};
        bit ens[8]  = '{1, 1, 0, 0, 0, 1, 1, 1};
        int nvalid = 0;
        int at = -1;
        for (int i = 0; i < 8; i++) begin
            drive(ens[i] ? bits[i] : 1'($urandom_range(0, 1)), ens[i], 0);
            if (valid_o === 1'b1) begin nvalid++; at = i; end
            checks++;
            if ({valid_o, locked_o, align_err_o, data_o} !== {m_valid, m_locked, m_err, m_data}) begin
                fails++;
                $display("FAIL gap_model cyc%0d: got v%b l%b e%b d%b, expected v%b l%b e%b d%b", i,
                         valid_o, locked_o, align_err_o, data_o, m_valid, m_locked, m_err, m_data);
            end
        end
        checks++;
        if (nvalid != 1 || at != 7 || data_o !== 5'b01100) begin
            fails++;
            $display("FAIL gap_word: got %0d strobes last at cyc%0d d=%b, expected 1 at cyc7 d=01100",
                     nvalid, at, data_o);
        end
    endtask

    task automatic test_bitslip();
        int pos[$];
        for (int i = 0; i < 5; i++) drive(1'($urandom_range(0, 1)), 1, 0);
        checks++;
        if (valid_o !== 1'b1) begin
            fails++;
            $display("FAIL bitslip_pre_word: got valid %b, expected 1", valid_o);
        end
        for (int k = 1; k <= 16; k++) begin
            drive(1'($urandom_range(0, 1)), 1, k == 1);
            if (valid_o === 1'b1) pos.push_back(k);
            checks++;
            if ({valid_o, data_o} !== {m_valid, m_data}) begin
                fails++;
                $display("FAIL bitslip_model k%0d: got v%b d%b, expected v%b d%b",
                         k, valid_o, data_o, m_valid, m_data);
            end
        end
        checks++;
        if (pos.size() != 3 || pos[0] != 6 || pos[1] != 11 || pos[2] != 16) begin
            fails++;
            $display("FAIL bitslip_spacing: got %0d strobes first at %0d, expected at 6,11,16",
                     pos.size(), pos.size() > 0 ? pos[0] : -1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), ($urandom_range(0, 15) == 0));
            checks++;
            if ({valid_o, locked_o, align_err_o, data_o} !== {m_valid, m_locked, m_err, m_data}) begin
                fails++;
                $display("FAIL random_model cyc%0d: got v%b l%b e%b d%b, expected v%b l%b e%b d%b", i,
                         valid_o, locked_o, align_err_o, data_o, m_valid, m_locked, m_err, m_data);
            end
        end
    endtask

    task automatic test_reset_midword();
        for (int i = 0; i < 3; i++) drive(1'($urandom_range(0, 1)), 1, 0);
        assert_reset();
        checks++;
        if ({data_o, valid_o, locked_o, align_err_o} !== 8'h00) begin
            fails++;
            $display("FAIL midword_reset: got d=%b v=%b l=%b e=%b, expected all 0",
                     data_o, valid_o, locked_o, align_err_o);
        end
        release_reset();
        drive(0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom_range(0, 1)), 1, 0);
            checks++;
            if ({valid_o, locked_o, align_err_o, data_o} !== {m_valid, m_locked, m_err, m_data}) begin
                fails++;
                $display("FAIL midword_model bit%0d: got v%b l%b d%b, expected v%b l%b d%b", i,
                         valid_o, locked_o, data_o, m_valid, m_locked, m_data);
            end
            if (!ALIGN) begin
                checks++;
                if (valid_o !== (i == 4)) begin
                    fails++;
                    $display("FAIL midword_valid bit%0d: got %b, expected %b", i, valid_o, (i == 4));
                end
            end
        end
    endtask

`ifdef DESER_ALIGN_EN
    task automatic test_align_err();
        int err_at = -1;
        int nerr = 0;
        bit lock_seen = 0;
        logic [4:0] zero = 5'b00000;
        assert_reset();
        release_reset();
        drive(0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            drive(i < 5 ? SYNC[4 - i] : zero[9 - i], 1, 0);
            if (align_err_o === 1'b1) begin nerr++; err_at = i; end
            if (locked_o !== 1'b0) lock_seen = 1;
            checks++;
            if ({valid_o, locked_o, align_err_o} !== {m_valid, m_locked, m_err}) begin
                fails++;
                $display("FAIL align_err_model bit%0d: got v%b l%b e%b, expected v%b l%b e%b", i,
                         valid_o, locked_o, align_err_o, m_valid, m_locked, m_err);
            end
        end
        checks++;
        if (nerr != 1 || err_at != 9 || lock_seen) begin
            fails++;
            $display("FAIL align_err_pulse: got %0d pulses last at bit%0d locked_seen=%b, expected 1 at bit9 never locked",
                     nerr, err_at, lock_seen);
        end
    endtask

    task automatic test_align_lock();
        bit seq[$];
        logic [4:0] payload = 5'b01010;
        int lock_at = -1;
        int early_valid = 0;
        int valid_at = -1;
        assert_reset();
        release_reset();
        drive(0, 1, 0);
        seq = '{0, 0};
        for (int r = 0; r < LOCKN; r++) for (int b = 4; b >= 0; b--) seq.push_back(SYNC[b]);
        for (int b = 4; b >= 0; b--) seq.push_back(payload[b]);
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i], 1, 0);
            if (locked_o === 1'b1 && lock_at < 0) lock_at = i;
            if (valid_o === 1'b1) begin
                if (lock_at < 0 || lock_at == i) early_valid++;
                else valid_at = i;
            end
            checks++;
            if ({valid_o, locked_o, align_err_o, data_o} !== {m_valid, m_locked, m_err, m_data}) begin
                fails++;
                $display("FAIL align_lock_model bit%0d: got v%b l%b e%b d%b, expected v%b l%b e%b d%b", i,
                         valid_o, locked_o, align_err_o, data_o, m_valid, m_locked, m_err, m_data);
            end
        end
        checks++;
        if (lock_at != 21 || early_valid != 0 || valid_at != 26 || data_o !== 5'b01010) begin
            fails++;
            $display("FAIL align_lock: got lock@%0d early_valid=%0d valid@%0d d=%b, expected lock@21 0 valid@26 d=01010",
                     lock_at, early_valid, valid_at, data_o);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
`ifdef DESER_ALIGN_EN
        test_align_err();
        test_align_lock();
`else
        test_basic();
        test_gap();
        test_bitslip();
`endif
        test_random();
        test_reset_midword();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/deserializer_nbit.md
# deserializer_nbit

Parametrised serial-to-parallel converter for the F2F LVDS receive path; the next-generation replacement for the fixed 5-bit deserializer. Shifts one bit per enabled clock into a WIDTH-bit word, presents each completed word with a one-cycle valid strobe, supports a runtime bitslip, and optionally hunts for a sync pattern to establish word alignment before releasing data. Sits between the LVDS input sampler and the RX framing logic.

## Interface
- WIDTH, 5, word width in bits; legal range is WIDTH ≥ 2.
- SYNC_PATTERN, 5'b11100, alignment word, WIDTH bits wide; used only when alignment is compiled in.
- LOCK_CNT, 4, number of consecutive aligned sync words required to lock; legal range is LOCK_CNT ≥ 1.
- clk  input  1  sole clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- serial_i  input  1  serial data bit, sampled on each rising edge when enable_i=1.
- enable_i  input  1  bit-valid qualifier; when 0, nothing is sampled and all state holds.
- bitslip_i  input  1  single-cycle request to shift the word boundary by one bit.
- data_o  output  WIDTH  last completed word; first-received bit is the MSB.
- valid_o  output  1  one-cycle strobe; data_o was updated on this edge.
- locked_o  output  1  high while in READ_DATA.
- align_err_o  output  1  one-cycle pulse on an alignment verify failure; constant 0 without ALIGN.

## Operation
- Internal state: shift register sr[WIDTH-1:0], bit counter bcnt (range 0..WIDTH-1), match counter mcnt, and a state register.
- Reset (asynchronous) sets state=INIT, sr=0, bcnt=0, mcnt=0, data_o=0, valid_o=0, locked_o=0, align_err_o=0.
- INIT: lasts exactly one clock after reset deasserts and samples nothing.
  - Without alignment, INIT → READ_DATA.
  - With alignment, INIT → HUNT.
- Each enabled cycle computes w = {sr[WIDTH-2:0], serial_i}; sr ← w.
- READ_DATA: bcnt increments on each enabled cycle.
  - When bcnt=WIDTH-1: data_o ← w, valid_o=1, bcnt ← 0.
- Bitslip: when bitslip_i=1 and enable_i=1 in READ_DATA, the bit is shifted in but bcnt does not increment, so the word completes one bit later.
  - If bitslip coincides with bcnt=WIDTH-1, no word is emitted that cycle; it is emitted on the next enabled cycle.
  - bitslip_i is ignored outside READ_DATA and when enable_i=0.
- enable_i=0: sr, bcnt, mcnt, state and data_o all hold; valid_o and align_err_o are 0.
- valid_o is only ever asserted in READ_DATA.

## Timing
- Latency: data_o and valid_o update on the same edge that samples the last bit of the word (registered, no extra stage).
- Worst-case valid_o rate is one strobe per WIDTH enabled cycles.
- locked_o is registered and rises on the edge of the transition into READ_DATA.
- Reset asserted mid-word discards the partial word.
  - Outputs clear immediately (asynchronously).
  - INIT repeats on the first edge after reset release.

## Configuration
- Macro DESER_ALIGN_EN.
- Defined: the states HUNT and VERIFY exist.
  - HUNT: on each enabled cycle, if w==SYNC_PATTERN then bcnt ← 0, mcnt ← 1. If LOCK_CNT=1, go to READ_DATA; otherwise go to VERIFY.
  - VERIFY: bcnt counts as in READ_DATA. At each word boundary:
    - If w==SYNC_PATTERN, mcnt increments; when it reaches LOCK_CNT, go to READ_DATA.
    - Otherwise pulse align_err_o, set mcnt ← 0, and return to HUNT.
  - No valid_o is issued in HUNT or VERIFY.
  - Once in READ_DATA, the block stays locked until reset.
- Undefined: INIT → READ_DATA directly. align_err_o is tied to 0; SYNC_PATTERN and LOCK_CNT are unused.

## Test plan
- Macro off, WIDTH=5: release reset, hold enable=1, send 1,0,1,1,0 starting at edge 2 → data_o=5'b10110 with valid_o high for exactly edge 6; locked_o=1 from edge 1.
- Macro off: send 0,1,1,0,0 with enable=0 for 3 cycles after the 2nd bit → data_o=5'b01100 with valid_o 3 cycles later than the no-gap case, no spurious strobe.
- Macro off: after one aligned word, pulse bitslip_i for 1 cycle → next valid_o arrives 6 enabled cycles after the previous one; subsequent strobes are every 5 cycles.
- Macro on, LOCK_CNT=4: send 2 bits of 0, then 11100 ×4, then 01010 → locked_o rises on the edge sampling the last bit of the 4th sync word; the next strobe carries data_o=5'b01010; no valid_o before lock.
- Macro on: send 11100 then 00000 → align_err_o pulses for one cycle at the 2nd word boundary, state returns to HUNT, locked_o stays 0.
- Any mode: assert reset after 3 bits of a word → data_o=0, valid_o=0 and locked_o=0 immediately; after release, a full 5-bit word is required before the next strobe.
